// File: rtl/io_mmio_fifo_port.sv
// MMIO responder bridging CPU loads/stores to RX/TX valid-ready streams through FIFOs.
// Define MMIO_FIFO_IRQ_EN to add the registered irq output and its CTRL enables.
module io_mmio_fifo_port #(
    parameter int FIFO_AW = 3,
    parameter int DATA_W  = 32
) (
    input  logic              io_clk,
    input  logic              resetn,
    input  logic [31:0]       addr,
    input  logic [31:0]       datain,
    input  logic              write_io_enable,
    input  logic              read_io_enable,
    output logic [31:0]       io_read_data,
    input  logic [DATA_W-1:0] rx_in_data,
    input  logic              rx_in_valid,
    output logic              rx_in_ready,
    output logic [DATA_W-1:0] tx_out_data,
    output logic              tx_out_valid,
    input  logic              tx_out_ready
`ifdef MMIO_FIFO_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CNT_W = FIFO_AW + 1;
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    typedef enum logic [1:0] {
        REG_RX_DATA = 2'd0,
        REG_TX_DATA = 2'd1,
        REG_STATUS  = 2'd2,
        REG_CTRL    = 2'd3
    } mmio_reg_e;

    mmio_reg_e          sel_reg;
    logic               io_sel, wr, rd;
    logic               flush, clear;
    logic               rx_pop_req, tx_push_req;
    logic               rx_push, rx_pop, tx_push, tx_pop;
    logic               rx_empty, rx_full, tx_empty, tx_full;
    logic               rx_underflow, tx_overflow;
    logic [1:0]         irq_en_bits;
    logic [31:0]        status;
    logic [FIFO_AW-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
    logic [CNT_W-1:0]   rx_count, tx_count;
    logic [DATA_W-1:0]  rx_mem [DEPTH];
    logic [DATA_W-1:0]  tx_mem [DEPTH];
    logic               unused_addr_bits;

    assign unused_addr_bits = ^{addr[31:8], addr[6:4], addr[1:0]};

    assign sel_reg = mmio_reg_e'(addr[3:2]);
    assign io_sel  = addr[7];
    assign wr      = write_io_enable & io_sel;
    assign rd      = read_io_enable & io_sel;

    assign flush       = wr & (sel_reg == REG_CTRL) & datain[1];
    assign clear       = wr & (sel_reg == REG_CTRL) & datain[0];
    assign rx_pop_req  = rd & (sel_reg == REG_RX_DATA);
    assign tx_push_req = wr & (sel_reg == REG_TX_DATA);

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == CNT_W'(DEPTH));
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == CNT_W'(DEPTH));

    assign rx_in_ready  = !rx_full;
    assign tx_out_valid = !tx_empty;
    assign tx_out_data  = tx_mem[tx_rd_ptr];

    // Flush discards any push landing on the same edge.
    assign rx_push = rx_in_valid & rx_in_ready & !flush;
    assign rx_pop  = rx_pop_req & !rx_empty;
    assign tx_push = tx_push_req & !tx_full & !flush;
    assign tx_pop  = tx_out_valid & tx_out_ready;

    // NOTE: storage arrays carry no reset; pointers and counts alone define occupancy.
    always_ff @(posedge io_clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_in_data;
        if (tx_push) tx_mem[tx_wr_ptr] <= DATA_W'(datain);
    end

    always_ff @(posedge io_clk) begin
        if (!resetn) begin
            rx_wr_ptr    <= '0;
            rx_rd_ptr    <= '0;
            rx_count     <= '0;
            tx_wr_ptr    <= '0;
            tx_rd_ptr    <= '0;
            tx_count     <= '0;
            rx_underflow <= 1'b0;
            tx_overflow  <= 1'b0;
        end else begin
            if (flush) begin
                rx_wr_ptr <= '0;
                rx_rd_ptr <= '0;
                rx_count  <= '0;
                tx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
                tx_count  <= '0;
            end else begin
                if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
                if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
                if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
                if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
                rx_count <= rx_count + CNT_W'(rx_push) - CNT_W'(rx_pop);
                tx_count <= tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);
            end
            // Set takes priority over a same-edge clear.
            rx_underflow <= (rx_pop_req & rx_empty) | (rx_underflow & !clear);
            tx_overflow  <= (tx_push_req & tx_full & !flush) | (tx_overflow & !clear);
        end
    end

`ifdef MMIO_FIFO_IRQ_EN
    logic rx_irq_en, tx_irq_en;

    always_ff @(posedge io_clk) begin
        if (!resetn) begin
            rx_irq_en <= 1'b0;
            tx_irq_en <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr && sel_reg == REG_CTRL) begin
                rx_irq_en <= datain[2];
                tx_irq_en <= datain[3];
            end
            irq <= (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty);
        end
    end

    assign irq_en_bits = {tx_irq_en, rx_irq_en};
`else
    assign irq_en_bits = 2'b00;
`endif

    assign status = {8'h00, 8'(tx_count), 8'(rx_count), irq_en_bits,
                     tx_overflow, rx_underflow, tx_full, tx_empty, rx_full, rx_empty};

    // NOTE: default assigned first so every path through the mux drives the output (no latch).
    always_comb begin
        io_read_data = '0;
        if (io_sel) begin
            case (sel_reg)
                REG_RX_DATA: if (!rx_empty) io_read_data = 32'(rx_mem[rx_rd_ptr]);
                REG_STATUS:  io_read_data = status;
                default:     io_read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_mmio_fifo_port.sv
// Self-checking bench for io_mmio_fifo_port: decode vector table, stream scoreboards,
// and hand-written sequences for the multi-cycle corner cases.
module tb_io_mmio_fifo_port;

    logic        io_clk;
    logic        resetn;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        write_io_enable;
    logic        read_io_enable;
    logic [31:0] io_read_data;
    logic [31:0] rx_in_data;
    logic        rx_in_valid;
    logic        rx_in_ready;
    logic [31:0] tx_out_data;
    logic        tx_out_valid;
    logic        tx_out_ready;
`ifdef MMIO_FIFO_IRQ_EN
    logic        irq;
`endif

    io_mmio_fifo_port dut (
        .io_clk          (io_clk),
        .resetn          (resetn),
        .addr            (addr),
        .datain          (datain),
        .write_io_enable (write_io_enable),
        .read_io_enable  (read_io_enable),
        .io_read_data    (io_read_data),
        .rx_in_data      (rx_in_data),
        .rx_in_valid     (rx_in_valid),
        .rx_in_ready     (rx_in_ready),
        .tx_out_data     (tx_out_data),
        .tx_out_valid    (tx_out_valid),
        .tx_out_ready    (tx_out_ready)
`ifdef MMIO_FIFO_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] rx_q[$];
    logic [31:0] tx_q[$];
    logic [31:0] exp_tx;

    typedef struct packed {
        logic [31:0] a;
        logic        we;
        logic        re;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_status;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
        if (a[7]) begin
            case (a[3:2])
                2'd1: if (tx_q.size() < 8) tx_q.push_back(d);
                2'd3: if (d[1]) begin
                    tx_q.delete();
                    rx_q.delete();
                end
                default: ;
            endcase
        end
    endfunction

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        datain = d;
        write_io_enable = 1'b1;
        model_write(a, d);
        tick();
        write_io_enable = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] rd);
        addr = a;
        read_io_enable = 1'b1;
        #1;
        rd = io_read_data;
        tick();
        read_io_enable = 1'b0;
    endtask

    task automatic peek_status(output logic [31:0] s);
        addr = 32'h88;
        #1;
        s = io_read_data;
    endtask

    task automatic rx_push(input logic [31:0] d);
        rx_in_data = d;
        rx_in_valid = 1'b1;
        #1;
        check("rx_in_ready before push", {31'b0, rx_in_ready}, {31'b0, rx_q.size() < 8});
        if (rx_q.size() < 8) rx_q.push_back(d);
        tick();
        rx_in_valid = 1'b0;
    endtask

    task automatic rx_drain(input int n, input string name);
        logic [31:0] rd;
        logic [31:0] exp;
        for (int i = 0; i < n; i++) begin
            exp = (rx_q.size() > 0) ? rx_q.pop_front() : 32'h0;
            load(32'h80, rd);
            check(name, rd, exp);
        end
    endtask

    // TX scoreboard: every word the device accepts must match the oldest outstanding store.
    always @(negedge io_clk) begin
        if (resetn === 1'b1 && tx_out_valid === 1'b1 && tx_out_ready === 1'b1) begin
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_stream: got %h while nothing was outstanding", tx_out_data);
            end else begin
                exp_tx = tx_q.pop_front();
                check("tx_stream data", tx_out_data, exp_tx);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        logic [31:0] rd;

        //              addr        we    re    wdata         rdata         status after
        vecs[0]  = '{32'h0000_0080, 1'b0, 1'b1, 32'h0,        32'h0,        32'h0000_0015};
        vecs[1]  = '{32'h0000_0000, 1'b0, 1'b1, 32'h0,        32'h0,        32'h0000_0015};
        vecs[2]  = '{32'h0000_0004, 1'b1, 1'b0, 32'h55,       32'h0,        32'h0000_0015};
        vecs[3]  = '{32'h0000_0084, 1'b1, 1'b0, 32'h1234,     32'h0,        32'h0001_0011};
        vecs[4]  = '{32'h0000_0084, 1'b0, 1'b1, 32'h0,        32'h0,        32'h0001_0011};
        vecs[5]  = '{32'h0000_008C, 1'b0, 1'b1, 32'h0,        32'h0,        32'h0001_0011};
        vecs[6]  = '{32'h0000_008C, 1'b1, 1'b0, 32'h1,        32'h0,        32'h0001_0001};
        vecs[7]  = '{32'h0000_0088, 1'b1, 1'b0, 32'hFFFF,     32'h0001_0001, 32'h0001_0001};
        vecs[8]  = '{32'h0000_0080, 1'b1, 1'b0, 32'h77,       32'h0,        32'h0001_0001};
        vecs[9]  = '{32'h0000_018B, 1'b0, 1'b1, 32'h0,        32'h0001_0001, 32'h0001_0001};
        vecs[10] = '{32'h0000_0084, 1'b1, 1'b0, 32'hBEEF,     32'h0,        32'h0002_0001};
        vecs[11] = '{32'h0000_008C, 1'b1, 1'b0, 32'h2,        32'h0,        32'h0000_0005};

        resetn = 1'b0;
        addr = 32'h80;
        datain = '0;
        write_io_enable = 1'b0;
        read_io_enable = 1'b0;
        rx_in_data = '0;
        rx_in_valid = 1'b0;
        tx_out_ready = 1'b0;

        // Reset held for two edges.
        tick();
        tick();
        resetn = 1'b1;
        #1;
        check("reset rx_data read", io_read_data, 32'h0);
        check("reset rx_in_ready", {31'b0, rx_in_ready}, 32'h1);
        check("reset tx_out_valid", {31'b0, tx_out_valid}, 32'h0);
        peek_status(s);
        check("reset status", s, 32'h0000_0005);

        // Register decode table.
        for (int i = 0; i < 12; i++) begin
            addr = vecs[i].a;
            datain = vecs[i].wdata;
            write_io_enable = vecs[i].we;
            read_io_enable = vecs[i].re;
            if (vecs[i].we) model_write(vecs[i].a, vecs[i].wdata);
            #1;
            check($sformatf("vec%0d rdata", i), io_read_data, vecs[i].exp_rdata);
            tick();
            write_io_enable = 1'b0;
            read_io_enable = 1'b0;
            peek_status(s);
            check($sformatf("vec%0d status", i), s, vecs[i].exp_status);
        end

        // RX fill to full, then drain past empty.
        for (int i = 0; i < 8; i++) rx_push(32'h11 + i);
        check("rx full ready", {31'b0, rx_in_ready}, 32'h0);
        peek_status(s);
        check("rx full status", s, 32'h0000_0806);
        rx_drain(8, "rx drain data");
        load(32'h80, rd);
        check("rx empty load", rd, 32'h0);
        peek_status(s);
        check("rx underflow status", s, 32'h0000_0015);

        // TX overflow with the device stalled, then in-order drain one per cycle.
        store(32'h8C, 32'h1);
        peek_status(s);
        check("clear sticky", s, 32'h0000_0005);
        for (int i = 0; i < 9; i++) store(32'h84, 32'hA0 + i);
        peek_status(s);
        check("tx full status", s, 32'h0008_0029);
        check("tx head", tx_out_data, 32'hA0);
        tx_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx drain valid %0d", i), {31'b0, tx_out_valid}, 32'h1);
            tick();
        end
        check("tx drained valid", {31'b0, tx_out_valid}, 32'h0);
        check("tx drained queue", tx_q.size(), 32'h0);
        tx_out_ready = 1'b0;
        store(32'h8C, 32'h1);

        // RX full: pop and offered push on the same edge -> pop only, push next cycle.
        for (int i = 0; i < 8; i++) rx_push(32'h21 + i);
        rx_in_data = 32'h29;
        rx_in_valid = 1'b1;
        #1;
        check("rx full refuses", {31'b0, rx_in_ready}, 32'h0);
        rx_drain(1, "rx pop while full");
        peek_status(s);
        check("rx count after pop", {24'b0, s[15:8]}, 32'h7);
        check("rx ready after pop", {31'b0, rx_in_ready}, 32'h1);
        tick();
        rx_q.push_back(32'h29);
        rx_in_valid = 1'b0;
        peek_status(s);
        check("rx count after push", {24'b0, s[15:8]}, 32'h8);
        rx_drain(8, "rx wrap data");

        // TX latency and simultaneous push+pop.
        tx_out_ready = 1'b1;
        store(32'h84, 32'hC1);
        check("tx latency valid", {31'b0, tx_out_valid}, 32'h1);
        check("tx latency data", tx_out_data, 32'hC1);
        store(32'h84, 32'hC2);
        peek_status(s);
        check("tx push+pop count", {24'b0, s[23:16]}, 32'h1);
        tick();
        check("tx idle valid", {31'b0, tx_out_valid}, 32'h0);
        check("tx idle queue", tx_q.size(), 32'h0);
        tx_out_ready = 1'b0;

        // Flush with an RX push on the same edge: flush wins.
        store(32'h84, 32'hD1);
        rx_push(32'hE1);
        rx_in_data = 32'hE2;
        rx_in_valid = 1'b1;
        store(32'h8C, 32'h2);
        rx_in_valid = 1'b0;
        peek_status(s);
        check("flush status", s, 32'h0000_0005);
        check("flush tx_out_valid", {31'b0, tx_out_valid}, 32'h0);

        // Reset mid-transfer drops pending TX words.
        store(32'h84, 32'hF1);
        store(32'h84, 32'hF2);
        check("pre-reset tx_out_valid", {31'b0, tx_out_valid}, 32'h1);
        resetn = 1'b0;
        tick();
        check("reset edge tx_out_valid", {31'b0, tx_out_valid}, 32'h0);
        tx_q.delete();
        rx_q.delete();
        resetn = 1'b1;
        peek_status(s);
        check("post-reset status", s, 32'h0000_0005);

`ifdef MMIO_FIFO_IRQ_EN
        store(32'h8C, 32'h4);
        peek_status(s);
        check("irq enable status", s, 32'h0000_0045);
        check("irq idle", {31'b0, irq}, 32'h0);
        rx_push(32'h99);
        check("irq one cycle after push", {31'b0, irq}, 32'h0);
        tick();
        check("irq two cycles after push", {31'b0, irq}, 32'h1);
        rx_drain(1, "irq rx data");
        check("irq one cycle after pop", {31'b0, irq}, 32'h1);
        tick();
        check("irq two cycles after pop", {31'b0, irq}, 32'h0);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
